// File: rtl/fractional_baud_generator_if.sv
// ----------------------------------------------------------------------------
// fractional_baud_generator_if
// Control and status bundle for the fractional baud generator.
//   enable            generator runs when high; all counters hold when low
//   load_strobe       1-cycle pulse capturing divisor_integer/divisor_fraction
//   divisor_integer   requested integer divisor (valid only when >= 2)
//   divisor_fraction  requested fractional divisor, in 1/2^FRACTION_WIDTH steps
//   resync            1-cycle pulse realigning the bit phase to mid-bit
//   sampling_tick     1-cycle pulse at the oversampling rate
//   tick              1-cycle pulse at the bit rate (coincides with a sampling_tick)
//   config_pending    a captured divisor is waiting for the next bit boundary
//   config_error      sticky; the last load carried divisor_integer < 2
// master: the controlling side (UART core / bench); slave: the generator.
// ----------------------------------------------------------------------------
interface fractional_baud_generator_if #(
    parameter int DIVISOR_WIDTH  = 16,
    parameter int FRACTION_WIDTH = 4
);
    logic                      enable;
    logic                      load_strobe;
    logic [DIVISOR_WIDTH-1:0]  divisor_integer;
    logic [FRACTION_WIDTH-1:0] divisor_fraction;
    logic                      resync;
    logic                      sampling_tick;
    logic                      tick;
    logic                      config_pending;
    logic                      config_error;

    modport master (
        output enable, load_strobe, divisor_integer, divisor_fraction, resync,
        input  sampling_tick, tick, config_pending, config_error
    );

    modport slave (
        input  enable, load_strobe, divisor_integer, divisor_fraction, resync,
        output sampling_tick, tick, config_pending, config_error
    );
endinterface

// File: rtl/fractional_baud_generator.sv
// ----------------------------------------------------------------------------
// fractional_baud_generator
// Runtime-programmable UART baud generator. The sampling period is
// divisor_integer + divisor_fraction/2^FRACTION_WIDTH clock cycles, realised
// by a prescaler that occasionally stretches a period by one cycle when a
// fractional accumulator carries. Every OVERSAMPLE sampling ticks a bit-rate
// tick is issued. New divisors are staged and only take effect on a bit
// boundary so a bit never changes rate half-way through.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   fractional_baud_generator_if.slave (controls in, ticks/status out)
// ----------------------------------------------------------------------------
module fractional_baud_generator #(
    parameter int DIVISOR_WIDTH    = 16,
    parameter int FRACTION_WIDTH   = 4,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_INTEGER  = 27,
    parameter int DEFAULT_FRACTION = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    fractional_baud_generator_if.slave    bus
);
    localparam int OS_WIDTH = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    typedef logic [DIVISOR_WIDTH-1:0]  int_t;
    typedef logic [FRACTION_WIDTH-1:0] frac_t;
    typedef logic [OS_WIDTH-1:0]       os_t;

    localparam int_t  MIN_INTEGER = int_t'(2);
    localparam os_t   OS_LAST     = os_t'(OVERSAMPLE - 1);
    localparam os_t   OS_MID      = os_t'(OVERSAMPLE / 2);

    int_t  prescale_q,       prescale_d;
    frac_t frac_acc_q,       frac_acc_d;
    logic  extra_q,          extra_d;
    os_t   os_count_q,       os_count_d;
    int_t  active_int_q,     active_int_d;
    frac_t active_frac_q,    active_frac_d;
    int_t  pend_int_q,       pend_int_d;
    frac_t pend_frac_q,      pend_frac_d;
    logic  config_pending_q, config_pending_d;
    logic  config_error_q,   config_error_d;
    logic  sampling_tick_q,  sampling_tick_d;
    logic  tick_q,           tick_d;

    // Terminal count is evaluated one bit wider so ActiveInt-1+ExtraCycle
    // can never wrap for the largest divisor.
    logic [DIVISOR_WIDTH:0]  term_count;
    logic                    terminal;
    logic [FRACTION_WIDTH:0] frac_sum;

    always_comb begin
        term_count = {1'b0, active_int_q} - (DIVISOR_WIDTH+1)'(1)
                   + {{DIVISOR_WIDTH{1'b0}}, extra_q};
        // >= rather than == so a divisor swapped in while disabled can never
        // leave the count stranded above the new terminal value.
        terminal   = ({1'b0, prescale_q} >= term_count);
        frac_sum   = {1'b0, frac_acc_q} + {1'b0, active_frac_q};
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path
        // through this block leaves one unassigned and no latch is inferred.
        prescale_d       = prescale_q;
        frac_acc_d       = frac_acc_q;
        extra_d          = extra_q;
        os_count_d       = os_count_q;
        active_int_d     = active_int_q;
        active_frac_d    = active_frac_q;
        pend_int_d       = pend_int_q;
        pend_frac_d      = pend_frac_q;
        config_pending_d = config_pending_q;
        config_error_d   = config_error_q;
        sampling_tick_d  = 1'b0;
        tick_d           = 1'b0;

        if (bus.enable) begin
            if (bus.resync) begin
                // Restart the bit half-way through; this wins over a coincident
                // terminal count, so no tick is issued this cycle.
                prescale_d = '0;
                frac_acc_d = '0;
                extra_d    = 1'b0;
                os_count_d = OS_MID;
            end else if (terminal) begin
                prescale_d      = '0;
                frac_acc_d      = frac_sum[FRACTION_WIDTH-1:0];
                extra_d         = frac_sum[FRACTION_WIDTH];
                os_count_d      = os_count_q + os_t'(1);
                sampling_tick_d = 1'b1;
                if (os_count_q == OS_LAST) begin
                    tick_d = 1'b1;
                    // Bit boundary: the only point a staged divisor may take
                    // effect while running. The fractional phase restarts too.
                    if (config_pending_q) begin
                        active_int_d     = pend_int_q;
                        active_frac_d    = pend_frac_q;
                        config_pending_d = 1'b0;
                        frac_acc_d       = '0;
                        extra_d          = 1'b0;
                    end
                end
            end else begin
                prescale_d = prescale_q + int_t'(1);
            end
        end else if (config_pending_q) begin
            // Nothing is being timed, so the staged divisor can go live at once.
            active_int_d     = pend_int_q;
            active_frac_d    = pend_frac_q;
            config_pending_d = 1'b0;
        end

        // Loads are evaluated after the apply so that a load landing on a
        // boundary edge is staged for the following boundary (last load wins).
        if (bus.load_strobe) begin
            if (bus.divisor_integer < MIN_INTEGER) begin
                config_error_d = 1'b1;
            end else begin
                pend_int_d       = bus.divisor_integer;
                pend_frac_d      = bus.divisor_fraction;
                config_pending_d = 1'b1;
                config_error_d   = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values computed above regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q       <= '0;
            frac_acc_q       <= '0;
            extra_q          <= 1'b0;
            os_count_q       <= '0;
            active_int_q     <= int_t'(DEFAULT_INTEGER);
            active_frac_q    <= frac_t'(DEFAULT_FRACTION);
            pend_int_q       <= '0;
            pend_frac_q      <= '0;
            config_pending_q <= 1'b0;
            config_error_q   <= 1'b0;
            sampling_tick_q  <= 1'b0;
            tick_q           <= 1'b0;
        end else begin
            prescale_q       <= prescale_d;
            frac_acc_q       <= frac_acc_d;
            extra_q          <= extra_d;
            os_count_q       <= os_count_d;
            active_int_q     <= active_int_d;
            active_frac_q    <= active_frac_d;
            pend_int_q       <= pend_int_d;
            pend_frac_q      <= pend_frac_d;
            config_pending_q <= config_pending_d;
            config_error_q   <= config_error_d;
            sampling_tick_q  <= sampling_tick_d;
            tick_q           <= tick_d;
        end
    end

    assign bus.sampling_tick  = sampling_tick_q;
    assign bus.tick           = tick_q;
    assign bus.config_pending = config_pending_q;
    assign bus.config_error   = config_error_q;
endmodule

// File: tb/tb_fractional_baud_generator.sv
// ----------------------------------------------------------------------------
// tb_fractional_baud_generator
// Directed bench for fractional_baud_generator (OVERSAMPLE = 16,
// FRACTION_WIDTH = 4). A period-based reference model predicts the tick and
// status outputs every cycle; directed measurements of tick spacing pin the
// model to hand-computed numbers.
// ----------------------------------------------------------------------------
module tb_fractional_baud_generator;
    localparam int DW   = 16;
    localparam int FW   = 4;
    localparam int OS   = 16;
    localparam int DEFI = 27;
    localparam int DEFF = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_on  = 1'b0;

    fractional_baud_generator_if #(.DIVISOR_WIDTH(DW), .FRACTION_WIDTH(FW)) bus ();

    fractional_baud_generator #(
        .DIVISOR_WIDTH(DW), .FRACTION_WIDTH(FW), .OVERSAMPLE(OS),
        .DEFAULT_INTEGER(DEFI), .DEFAULT_FRACTION(DEFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Thinks in whole sampling periods: a period lasts int+extra cycles, and
    // the carry of the fractional sum decides the extra cycle of the next one.
    int m_int, m_frac, m_pint, m_pfrac, m_elapsed, m_acc, m_extra, m_sidx;
    bit m_pend, m_err, e_st, e_tk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_int = DEFI; m_frac = DEFF; m_pint = 0; m_pfrac = 0;
            m_elapsed = 0; m_acc = 0; m_extra = 0; m_sidx = 0;
            m_pend = 0; m_err = 0; e_st = 0; e_tk = 0;
        end else begin
            e_st = 0;
            e_tk = 0;
            if (bus.enable) begin
                if (bus.resync) begin
                    m_elapsed = 0; m_acc = 0; m_extra = 0; m_sidx = OS / 2;
                end else if (m_elapsed + 1 >= m_int + m_extra) begin
                    int total;
                    total     = m_acc + m_frac;
                    m_extra   = total / (1 << FW);
                    m_acc     = total % (1 << FW);
                    m_elapsed = 0;
                    m_sidx    = (m_sidx + 1) % OS;
                    e_st      = 1;
                    if (m_sidx == 0) begin
                        e_tk = 1;
                        if (m_pend) begin
                            m_int = m_pint; m_frac = m_pfrac; m_pend = 0;
                            m_acc = 0; m_extra = 0;
                        end
                    end
                end else begin
                    m_elapsed++;
                end
            end else if (m_pend) begin
                m_int = m_pint; m_frac = m_pfrac; m_pend = 0;
            end
            if (bus.load_strobe) begin
                if (int'(bus.divisor_integer) < 2) m_err = 1;
                else begin
                    m_pint = int'(bus.divisor_integer);
                    m_pfrac = int'(bus.divisor_fraction);
                    m_pend = 1; m_err = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model sampling_tick",  int'(bus.sampling_tick),  int'(e_st));
            check("model tick",           int'(bus.tick),           int'(e_tk));
            check("model config_pending", int'(bus.config_pending), int'(m_pend));
            check("model config_error",   int'(bus.config_error),   int'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_for(input bit want_tick, input int budget, input string name,
                            output int at);
        bit seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (want_tick ? bus.tick : bus.sampling_tick) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    // Called at a negedge; returns at the negedge after the strobe was sampled.
    task automatic do_load(input int i, input int f);
        bus.divisor_integer  = DW'(i);
        bus.divisor_fraction = FW'(f);
        bus.load_strobe      = 1'b1;
        @(negedge clk);
        bus.load_strobe      = 1'b0;
    endtask

    int t0, t1, t2, t3, t4, c0, r_edge, s, prev;
    int periods[16];
    int quiet;

    initial begin
        bus.enable = 1'b0; bus.load_strobe = 1'b0; bus.resync = 1'b0;
        bus.divisor_integer = '0; bus.divisor_fraction = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset sampling_tick",  int'(bus.sampling_tick), 0);
        check("reset tick",           int'(bus.tick), 0);
        check("reset config_pending", int'(bus.config_pending), 0);
        check("reset config_error",   int'(bus.config_error), 0);

        // First-tick latency at the default divisor 27
        bus.enable = 1'b1;
        rst = 1'b0;
        c0 = cyc;
        wait_for(0, 100, "first sampling_tick", t0);
        check("first sampling_tick latency", t0 - c0, DEFI);
        wait_for(1, 600, "first tick", t1);
        check("first tick latency", t1 - c0, OS * DEFI);

        // T1: Int = 4, Frac = 0
        do_load(4, 0);
        check("T1 pending after load", int'(bus.config_pending), 1);
        wait_for(1, 600, "T1 apply", t0);
        check("T1 pending cleared on boundary", int'(bus.config_pending), 0);
        wait_for(0, 20, "T1 sampling", t1);
        check("T1 sampling period", t1 - t0, 4);
        wait_for(1, 100, "T1 tick a", t2);
        check("T1 tick period a", t2 - t0, 64);
        wait_for(1, 100, "T1 tick b", t3);
        check("T1 tick period b", t3 - t2, 64);

        // T2: Int = 4, Frac = 8 -> 4/5 alternation, 72 cycles per bit
        do_load(4, 8);
        wait_for(1, 100, "T2 apply", t0);
        wait_for(1, 100, "T2 tick a", t1);
        prev = t1;
        for (int k = 0; k < 16; k++) begin
            wait_for(0, 20, "T2 sampling", s);
            periods[k] = s - prev;
            prev = s;
        end
        check("T2 16 sampling ticks span", prev - t1, 72);
        check("T2 16th sampling tick is tick", int'(bus.tick), 1);
        check("T2 period 1", periods[0], 5);
        check("T2 period 2", periods[1], 4);
        wait_for(1, 100, "T2 tick c", t2);
        check("T2 tick period", t2 - prev, 72);

        // T3: Int = 8 loaded mid-bit while running at 4
        do_load(4, 0);
        wait_for(1, 100, "T3 apply 4", t0);
        wait_for(1, 100, "T3 tick 0", t0);
        repeat (20) @(negedge clk);
        do_load(8, 0);
        check("T3 pending mid-bit", int'(bus.config_pending), 1);
        wait_for(1, 100, "T3 tick 1", t1);
        check("T3 bit still at old rate", t1 - t0, 64);
        check("T3 pending cleared", int'(bus.config_pending), 0);
        wait_for(1, 200, "T3 tick 2", t2);
        check("T3 bit at new rate", t2 - t1, 128);

        // T4: illegal load, then a valid one clears the error
        do_load(4, 0);
        wait_for(1, 200, "T4 apply 4", t0);
        do_load(1, 0);
        check("T4 error set", int'(bus.config_error), 1);
        check("T4 no pending on error", int'(bus.config_pending), 0);
        wait_for(1, 100, "T4 tick 1", t1);
        wait_for(1, 100, "T4 tick 2", t2);
        check("T4 rate stays 4", t2 - t1, 64);
        do_load(6, 0);
        check("T4 error cleared", int'(bus.config_error), 0);
        wait_for(1, 100, "T4 apply 6", t3);
        wait_for(1, 150, "T4 tick 6", t4);
        check("T4 rate 6", t4 - t3, 96);

        // T5: resync mid-bit, then resync on a terminal count with a load
        do_load(4, 0);
        wait_for(1, 150, "T5 apply 4", t0);
        wait_for(1, 100, "T5 tick", t0);
        repeat (9) @(negedge clk);
        bus.resync = 1'b1;
        r_edge = cyc + 1;
        @(negedge clk);
        bus.resync = 1'b0;
        check("T5 no sampling_tick on resync", int'(bus.sampling_tick), 0);
        check("T5 no tick on resync", int'(bus.tick), 0);
        wait_for(1, 100, "T5 tick after resync", t1);
        check("T5 resync to tick", t1 - r_edge, 32);
        wait_for(0, 20, "T5 sampling", s);
        repeat (3) @(negedge clk);
        bus.resync = 1'b1;
        bus.divisor_integer = DW'(4); bus.divisor_fraction = '0;
        bus.load_strobe = 1'b1;
        @(negedge clk);
        bus.resync = 1'b0; bus.load_strobe = 1'b0;
        check("T5 resync beats terminal", int'(bus.sampling_tick), 0);
        check("T5 load with resync", int'(bus.config_pending), 1);
        wait_for(1, 100, "T5 tick after terminal resync", t2);
        check("T5 terminal resync to tick", t2 - (s + 4), 32);

        // T6: enable low holds phase; async reset mid-bit
        wait_for(1, 100, "T6 tick", t0);
        repeat (20) @(negedge clk);
        wait_for(0, 20, "T6 sampling", s);
        @(negedge clk);
        bus.enable = 1'b0;
        quiet = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.sampling_tick || bus.tick) quiet++;
        end
        check("T6 no ticks while disabled", quiet, 0);
        bus.enable = 1'b1;
        wait_for(0, 20, "T6 sampling after enable", t1);
        check("T6 phase held", t1 - s, 54);
        do_load(6, 0);
        wait_for(0, 20, "T6 sampling before reset", t2);
        #1 rst = 1'b1;
        #1;
        check("T6 async reset sampling_tick", int'(bus.sampling_tick), 0);
        check("T6 async reset tick", int'(bus.tick), 0);
        check("T6 async reset pending", int'(bus.config_pending), 0);
        @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        wait_for(0, 100, "T6 sampling after reset", t3);
        check("T6 default divisor restored", t3 - c0, DEFI);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
